// File: rtl/xbar_mem_responder.sv
// -----------------------------------------------------------------------------
// xbar_mem_responder
//
// Memory-backed target on one crossbar master port. Read and write requests
// are accepted through a req/ack handshake. Write data goes into a word array.
// Read data comes back on resp/rdata a fixed RD_LATENCY cycles after the
// accept. Programmable wait states (ACK_DELAY) and a limit on outstanding
// reads (MAX_OUTSTANDING) let a bench create crossbar backpressure.
//
// Handshake: the master raises req and holds addr/cmd/wdata stable until ack.
// A transfer takes place on the rising edge where req && ack. ack is
// combinational and never high without req. resp is a one-cycle strobe with
// no backpressure. rdata keeps its last value while resp is low.
//
// Ports
//   aclk            in   clock, rising edge
//   aresetn         in   asynchronous active-low reset
//   req             in   request valid
//   addr            in   byte address (word index = addr[$clog2(DEPTH)+1:2])
//   cmd             in   0 = read, 1 = write
//   wdata           in   write data
//   ack             out  request accepted this cycle
//   rdata           out  read data, valid when resp = 1
//   resp            out  one-cycle read response strobe
//   dbg_state       out  FSM state (0 IDLE, 1 WAIT, 2 GRANT)
//   dbg_outstanding out  reads currently in flight
// -----------------------------------------------------------------------------
module xbar_mem_responder #(
    parameter int AWIDTH          = 32,
    parameter int DWIDTH          = 32,
    parameter int DEPTH           = 256,
    parameter int RD_LATENCY      = 2,
    parameter int ACK_DELAY       = 0,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              req,
    input  logic [AWIDTH-1:0] addr,
    input  logic              cmd,
    input  logic [DWIDTH-1:0] wdata,
    output logic              ack,
    output logic [DWIDTH-1:0] rdata,
    output logic              resp,
    output logic [1:0]        dbg_state,
    output logic [7:0]        dbg_outstanding
);

    localparam int IW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next, cnt_inc;
    logic              ack_c;
    logic              can_accept;
    logic              rd_acc, wr_acc;
    logic [OW-1:0]     outstanding;
    logic [IW-1:0]     idx;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] mem_rd;

    logic [RD_LATENCY-1:0] pipe_v;
    logic [DWIDTH-1:0]     pipe_d [RD_LATENCY];

    // Byte-lane bits and address bits above the array are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[AWIDTH-1:IW+2], addr[1:0]};

    assign idx    = addr[IW+1:2];
    assign mem_rd = mem[idx];

    // A read that leaves the pipe in this cycle still holds its slot; the
    // slot frees at the edge that ends the resp cycle.
    assign can_accept = cmd | (outstanding < OW'(MAX_OUTSTANDING));
    assign cnt_inc    = cnt + 4'd1;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // cnt counts the cycles req has been held. The move to GRANT happens
    // on the edge where cnt reaches ACK_DELAY, so the first ack falls in
    // cycle ACK_DELAY counted from the cycle req rose.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ack_c      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (ACK_DELAY == 0) begin
                        ack_c = can_accept;
                    end else begin
                        cnt_next   = 4'd1;
                        state_next = (ACK_DELAY == 1) ? ST_GRANT : ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_next = ST_IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == 4'(ACK_DELAY)) begin
                        state_next = ST_GRANT;
                    end
                end
            end
            ST_GRANT: begin
                if (!req) begin
                    state_next = ST_IDLE;
                    cnt_next   = 4'd0;
                end else if (can_accept) begin
                    ack_c      = 1'b1;
                    state_next = ST_IDLE;
                    cnt_next   = 4'd0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // ack is forced low while reset is asserted, so nothing is accepted then.
    assign ack    = ack_c & aresetn;
    assign rd_acc = ack & ~cmd;
    assign wr_acc = ack & cmd;

    // ---------------------------------------------------------------- memory
    // Memory contents are kept across reset.
    always_ff @(posedge aclk) begin
        if (wr_acc) begin
            mem[idx] <= wdata;
        end
    end

    // ---------------------------------------------------------- read pipe
    // Each data stage loads only when a valid entry moves into it. The last
    // stage therefore holds the previous response and drives rdata directly.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pipe_v <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= rd_acc;
            if (rd_acc) begin
                pipe_d[0] <= mem_rd;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) begin
                    pipe_d[i] <= pipe_d[i-1];
                end
            end
        end
    end

    assign resp  = pipe_v[RD_LATENCY-1];
    assign rdata = pipe_d[RD_LATENCY-1];

    // --------------------------------------------------------- outstanding
    // When a read is accepted in the same cycle that another read leaves,
    // the count stays the same.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outstanding <= '0;
        end else if (rd_acc && !resp) begin
            if (outstanding != OW'(MAX_OUTSTANDING)) begin
                outstanding <= outstanding + OW'(1);
            end
        end else if (!rd_acc && resp) begin
            if (outstanding != '0) begin
                outstanding <= outstanding - OW'(1);
            end
        end
    end

    assign dbg_state       = state;
    assign dbg_outstanding = 8'(outstanding);

    // --------------------------------------------------------- assertions
    a_out_max: assert property (@(posedge aclk) disable iff (!aresetn)
        outstanding <= OW'(MAX_OUTSTANDING));
    a_out_underflow: assert property (@(posedge aclk) disable iff (!aresetn)
        !(resp && !rd_acc && outstanding == '0));
    a_ack_needs_req: assert property (@(posedge aclk) disable iff (!aresetn)
        ack |-> req);

endmodule

// File: tb/tb_xbar_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_xbar_mem_responder
//
// Four responder instances share one clock and one reset:
//   u0 : defaults (ACK_DELAY 0, RD_LATENCY 2, MAX_OUTSTANDING 2)
//   u1 : ACK_DELAY 3
//   u2 : RD_LATENCY 3, MAX_OUTSTANDING 1
//   u3 : RD_LATENCY 4, MAX_OUTSTANDING 2 (two reads in flight across reset)
// Only one instance is active at a time, so one response queue is enough.
// Each entry is tagged with its instance and its expected response cycle.
// -----------------------------------------------------------------------------
module tb_xbar_mem_responder;

    localparam int NI = 4;

    logic        clk;
    logic        aresetn;
    logic        req     [NI];
    logic [31:0] addr    [NI];
    logic        cmd     [NI];
    logic [31:0] wdata   [NI];
    logic        ack     [NI];
    logic [31:0] rdata   [NI];
    logic        resp    [NI];
    logic [1:0]  dbg_state [NI];
    logic [7:0]  dbg_out [NI];

    int cyc;
    int n_checks;
    int n_pass;
    int n_fail;
    int max_out0;

    logic [31:0] model_mem [NI][256];
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    int          exp_inst_q[$];

    // ------------------------------------------------------ clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------- DUTs
    xbar_mem_responder u0 (
        .aclk(clk), .aresetn(aresetn), .req(req[0]), .addr(addr[0]), .cmd(cmd[0]),
        .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .resp(resp[0]),
        .dbg_state(dbg_state[0]), .dbg_outstanding(dbg_out[0]));

    xbar_mem_responder #(.ACK_DELAY(3)) u1 (
        .aclk(clk), .aresetn(aresetn), .req(req[1]), .addr(addr[1]), .cmd(cmd[1]),
        .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .resp(resp[1]),
        .dbg_state(dbg_state[1]), .dbg_outstanding(dbg_out[1]));

    xbar_mem_responder #(.RD_LATENCY(3), .MAX_OUTSTANDING(1)) u2 (
        .aclk(clk), .aresetn(aresetn), .req(req[2]), .addr(addr[2]), .cmd(cmd[2]),
        .wdata(wdata[2]), .ack(ack[2]), .rdata(rdata[2]), .resp(resp[2]),
        .dbg_state(dbg_state[2]), .dbg_outstanding(dbg_out[2]));

    xbar_mem_responder #(.RD_LATENCY(4), .MAX_OUTSTANDING(2)) u3 (
        .aclk(clk), .aresetn(aresetn), .req(req[3]), .addr(addr[3]), .cmd(cmd[3]),
        .wdata(wdata[3]), .ack(ack[3]), .rdata(rdata[3]), .resp(resp[3]),
        .dbg_state(dbg_state[3]), .dbg_outstanding(dbg_out[3]));

    // ------------------------------------------------------------ helpers
    function automatic int lat_of(input int i);
        case (i)
            2:       return 3;
            3:       return 4;
            default: return 2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Drive a request on instance i and hold it until ack, with a bounded
    // wait. Reads push the model value and the expected resp cycle.
    task automatic issue(input int i, input logic c, input logic [31:0] a,
                         input logic [31:0] d, output int acc_cyc, output int start_cyc);
        logic got;
        got       = 1'b0;
        acc_cyc   = -1;
        req[i]    = 1'b1;
        cmd[i]    = c;
        addr[i]   = a;
        wdata[i]  = d;
        start_cyc = cyc;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (ack[i]) begin
                got     = 1'b1;
                acc_cyc = cyc;
                if (c) begin
                    model_mem[i][a[9:2]] = d;
                end else begin
                    exp_q.push_back(model_mem[i][a[9:2]]);
                    exp_cyc_q.push_back(cyc + lat_of(i));
                    exp_inst_q.push_back(i);
                end
            end
            @(posedge clk);
            #1;
        end
        check($sformatf("ack_seen_u%0d_a%h", i, a), 32'(got), 32'd1);
    endtask

    task automatic drop(input int i);
        req[i] = 1'b0;
        cmd[i] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------- scoreboard
    always @(negedge clk) begin
        logic [31:0] d;
        int          c;
        int          n;
        for (int i = 0; i < NI; i++) begin
            if (resp[i]) begin
                check($sformatf("resp_expected_u%0d", i), 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    d = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    n = exp_inst_q.pop_front();
                    check("resp_instance", i, n);
                    check($sformatf("rdata_u%0d", i), rdata[i], d);
                    check($sformatf("resp_cycle_u%0d", i), cyc, c);
                end
            end
        end
        if (aresetn && int'(dbg_out[0]) > max_out0) max_out0 = int'(dbg_out[0]);
    end

    // ---------------------------------------------------------- stimulus
    initial begin
        int s, a0, a1, a2, a3;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        max_out0 = 0;
        cyc      = 0;
        for (int i = 0; i < NI; i++) begin
            req[i]   = 1'b0;
            cmd[i]   = 1'b0;
            addr[i]  = '0;
            wdata[i] = '0;
            for (int w = 0; w < 256; w++) model_mem[i][w] = '0;
        end

        // Reset, with a read request pending on u0 that must not be acked.
        aresetn = 1'b1;
        #1;
        aresetn = 1'b0;
        req[0]  = 1'b1;
        addr[0] = 32'h10;
        @(negedge clk);
        check("rst_ack", 32'(ack[0]), 32'd0);
        check("rst_resp", 32'(resp[0]), 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        check("rst_state", 32'(dbg_state[0]), 32'd0);
        check("rst_outstanding", 32'(dbg_out[0]), 32'd0);
        req[0] = 1'b0;
        cycles(2);
        aresetn = 1'b1;
        cycles(1);

        // Write then read the same word on back-to-back cycles.
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, a0, s);
        issue(0, 1'b0, 32'h10, 32'h0, a1, s);
        check("t1_back_to_back", a1 - a0, 32'd1);
        drop(0);
        drain("t1_drain");
        cycles(2);
        check("t1_rdata_hold", rdata[0], 32'hDEADBEEF);

        // Aliasing: upper and byte-lane address bits are ignored.
        issue(0, 1'b1, 32'h004, 32'h1, a0, s);
        issue(0, 1'b1, 32'h008, 32'h2, a0, s);
        issue(0, 1'b0, 32'h404, 32'h0, a0, s);
        issue(0, 1'b0, 32'h005, 32'h0, a0, s);
        issue(0, 1'b0, 32'h00B, 32'h0, a0, s);
        drop(0);
        drain("t2_drain");

        // Four reads with two allowed in flight: accepts at +0, +1, +3, +4.
        issue(0, 1'b1, 32'h0, 32'hA, a0, s);
        issue(0, 1'b1, 32'h4, 32'hB, a0, s);
        issue(0, 1'b1, 32'h8, 32'hC, a0, s);
        issue(0, 1'b1, 32'hC, 32'hD, a0, s);
        issue(0, 1'b0, 32'h0, 32'h0, a0, s);
        issue(0, 1'b0, 32'h4, 32'h0, a1, s);
        issue(0, 1'b0, 32'h8, 32'h0, a2, s);
        issue(0, 1'b0, 32'hC, 32'h0, a3, s);
        check("t5_acc1", a1 - a0, 32'd1);
        check("t5_acc2", a2 - a0, 32'd3);
        check("t5_acc3", a3 - a0, 32'd4);
        drop(0);
        drain("t5_drain");

        // Wait states: the first ack comes 3 cycles after req rises.
        issue(1, 1'b1, 32'h20, 32'h77, a0, s);
        check("t3_write_delay", a0 - s, 32'd3);
        issue(1, 1'b0, 32'h20, 32'h0, a0, s);
        check("t3_read_delay", a0 - s, 32'd3);
        drop(1);
        drain("t3_drain");
        // Request withdrawn in cycle 2: no ack, no resp, back to IDLE.
        req[1]  = 1'b1;
        cmd[1]  = 1'b0;
        addr[1] = 32'h20;
        @(negedge clk);
        check("t3w_ack_c0", 32'(ack[1]), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t3w_ack_c1", 32'(ack[1]), 32'd0);
        check("t3w_state_wait", 32'(dbg_state[1]), 32'd1);
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        @(negedge clk);
        check("t3w_ack_c2", 32'(ack[1]), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t3w_state_idle", 32'(dbg_state[1]), 32'd0);
        cycles(6);
        check("t3w_no_resp_pending", 32'(exp_q.size()), 32'd0);
        check("t3w_outstanding", 32'(dbg_out[1]), 32'd0);

        // One read in flight at a time; writes still go through at once.
        issue(2, 1'b1, 32'h40, 32'h55, a0, s);
        issue(2, 1'b1, 32'h44, 32'h66, a0, s);
        issue(2, 1'b1, 32'h48, 32'h77, a0, s);
        drop(2);
        issue(2, 1'b0, 32'h48, 32'h0, a0, s);
        issue(2, 1'b0, 32'h40, 32'h0, a1, s);
        issue(2, 1'b1, 32'h4C, 32'h99, a2, s);
        issue(2, 1'b0, 32'h4C, 32'h0, a3, s);
        check("t4_read_read", a1 - a0, 32'd4);
        check("t4_write_immediate", a2 - a1, 32'd1);
        check("t4_read_after_write", a3 - a1, 32'd4);
        drop(2);
        drain("t4_drain");

        // Reset with two reads in flight on u3.
        issue(3, 1'b1, 32'h80, 32'h1234, a0, s);
        issue(3, 1'b1, 32'h84, 32'h5678, a0, s);
        issue(3, 1'b0, 32'h80, 32'h0, a0, s);
        issue(3, 1'b0, 32'h84, 32'h0, a1, s);
        check("t6_inflight", 32'(dbg_out[3]), 32'd2);
        aresetn = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        exp_inst_q.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_ack_in_reset", 32'(ack[3]), 32'd0);
            check("t6_resp_in_reset", 32'(resp[3]), 32'd0);
        end
        check("t6_out_in_reset", 32'(dbg_out[3]), 32'd0);
        req[3] = 1'b0;
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        cycles(6);
        check("t6_no_late_resp", 32'(exp_q.size()), 32'd0);
        issue(3, 1'b0, 32'h80, 32'h0, a0, s);
        issue(3, 1'b0, 32'h84, 32'h0, a0, s);
        drop(3);
        drain("t6_drain");

        check("t5_max_outstanding_u0", max_out0, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
